mtm_pp_unit: RTL and testbench
==============================

Name: mtm_pp_unit

Overview:
- Parametrised successor to the single-tile matrix-transpose unit.
- Accepts NUM_PE x NUM_PE tiles one row per cycle and emits each tile either transposed (column-wise) or passed through (row-wise).
- Uses two ping-pong register banks, so one tile fills while the previous one drains. Sustained throughput is one row per cycle.
- Valid/ready handshakes on both sides let it sit between HE datapath stages that stall independently.

Parameters:
- DATA_WIDTH, 8, bits per element.
- NUM_PE, 4, tile dimension (rows = columns = elements per row beat); must be >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_val  in  1  input row valid.
- in_rdy  out  1  unit can accept a row.
- in_mode  in  1  1 = transpose, 0 = passthrough; sampled only with row 0 of a tile.
- input_row  in  NUM_PE*DATA_WIDTH  element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- out_val  out  1  output row valid.
- out_rdy  in  1  downstream accepts the row.
- output_row  out  NUM_PE*DATA_WIDTH  element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_last  out  1  high with the final output row of a tile.

Behaviour:
- Handshakes:
  - An input row is accepted when in_val & in_rdy at a rising edge.
  - An output row is accepted when out_val & out_rdy at a rising edge.
  - in_val/input_row must hold while in_val=1 and in_rdy=0. The unit holds output_row/out_last stable while out_val=1 and out_rdy=0.
- State: two banks B0/B1, each NUM_PE x NUM_PE DATA_WIDTH registers plus a 1-bit full flag and a stored mode bit.
  - Write side: wr_bank (1b), wr_row (clog2(NUM_PE)b).
  - Read side: rd_bank (1b), rd_idx (clog2(NUM_PE)b).
- Bank FSM per bank: EMPTY -> FILLING (row 0 accepted) -> FULL (row NUM_PE-1 accepted) -> EMPTY (last output row accepted).
  - FULL and "draining" are the same state; rd_idx tracks progress through the drain.
- Write path:
  - Accepted row r is stored at bank[wr_bank].M[wr_row][*]; wr_row then increments.
  - On row 0, in_mode is latched into the bank's mode bit. in_mode on other rows is ignored.
  - On row NUM_PE-1: set full, wr_row wraps to 0, wr_bank toggles.
- in_rdy = !rst & !full[wr_bank]. Combinational from registered state only; no in->rdy combinational path.
- Read path (combinational from bank registers):
  - out_val = full[rd_bank].
  - Transpose mode: output_row element i = M[i][rd_idx].
  - Passthrough mode: output_row element i = M[rd_idx][i].
  - out_last = out_val & (rd_idx == NUM_PE-1).
  - On an accepted output row rd_idx increments. On the last row, rd_idx wraps to 0, full[rd_bank] clears and rd_bank toggles.
- Latency: if the last input row of a tile is accepted at edge t and that bank is the read bank, out_val=1 in the cycle after t. Output row 0 is accepted no earlier than edge t+1.
- Simultaneous events:
  - A write to one bank and a read from the other in the same cycle are independent.
  - A bank freed at edge t reports in_rdy=1 from cycle t+1. There is no same-cycle reuse.
- Full: with both banks full, in_rdy=0 until the read bank drains.
- Empty: out_val=0, output_row shows the (stale or zero) contents of rd_bank. Checkers must ignore output_row when out_val=0.
- Reset (async, also mid-tile):
  - All elements are set to 0; full flags, mode bits, wr_bank, wr_row, rd_bank and rd_idx are cleared.
  - Outputs during and after reset: out_val=0, out_last=0, output_row=0, in_rdy=0 while rst=1 and 1 after release.
  - Partially written tiles are discarded.
- Widths: no arithmetic on data; counters wrap modulo NUM_PE at NUM_PE-1 explicitly, so non-power-of-2 NUM_PE is supported.

Decomposition:
- Package mtm_pkg holds:
  - mode_e enum (MODE_PASS=0, MODE_TRANSPOSE=1);
  - bank_state_e enum (EMPTY, FILLING, FULL);
  - localparam function for the counter width, clog2 with a minimum of 1.
- Sub-module mtm_bank: one NUM_PE x NUM_PE register tile with row-write port (wr_en, row index, row data), stored mode bit, full flag, and a combinational read of row-or-column by index.
- The top instantiates two mtm_bank instances plus the wr/rd pointer logic.

Test Plan:
All cases use DATA_WIDTH=8, NUM_PE=4, M0[i][j] = 0x10*i + 0x0A + j.
- Single tile, in_mode=1, out_rdy=1:
  - Rows {0A,0B,0C,0D}..{3A,3B,3C,3D} on 4 consecutive edges.
  - Cycle after the 4th edge: out_val=1, output_row={0A,1A,2A,3A}.
  - Then {0B,1B,2B,3B}, {0C,..}, {0D,1D,2D,3D} with out_last=1 on the 4th row only.
- Back-to-back 3 tiles (M0, M0+0x40, M0+0x80), out_rdy=1, in_val held high:
  - in_rdy never drops.
  - 12 output rows emitted contiguously starting the cycle after input edge 4.
  - Tile 2 row 0 = {4A,5A,6A,7A}.
- Backpressure, out_rdy=0 throughout:
  - 8 rows accepted, then in_rdy=0.
  - output_row stays {0A,1A,2A,3A} unchanged for 20 cycles.
  - Raising out_rdy drains tile 0 and then tile 1 in order; in_rdy=1 one cycle after tile 0's out_last handshake.
- Passthrough: tile M0 with in_mode=0 -> outputs {0A,0B,0C,0D}, {1A,..}, {2A,..}, {3A,3B,3C,3D}.
- Mode change mid-tile: in_mode=1 on row 0, toggled to 0 on rows 1-3 -> full tile output is transposed.
- Reset mid-tile:
  - Accept 2 rows of M0, then assert rst for 1 cycle.
  - out_val=0, output_row=0, in_rdy=0 during rst.
  - Then a full tile M0+0x40 produces exactly 4 transposed rows {4A,5A,6A,7A}.. with no stale data.

Source files
------------

// File: rtl/mtm_pkg.sv
// Shared types and helpers for the ping-pong matrix transpose unit.
package mtm_pkg;

   typedef enum logic {
      MODE_PASS      = 1'b0,
      MODE_TRANSPOSE = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_state_e;

   // Counter width for a 0..n-1 index; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mtm_bank.sv
// One NUM_PE x NUM_PE register tile: row-wise write port, stored mode,
// fill/drain state and a combinational row-or-column read.
module mtm_bank
   import mtm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PE     = 4,
   localparam int CW        = cnt_width(NUM_PE),
   localparam int RW        = NUM_PE * DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_row,
   input  logic [RW-1:0] wr_data,
   input  mode_e         wr_mode,
   input  logic          rd_done,
   input  logic [CW-1:0] rd_idx,
   output logic          full,
   output logic [RW-1:0] rd_data
);

   localparam logic [CW-1:0] LAST_ROW = CW'(NUM_PE - 1);

   logic [RW-1:0] mem_q [NUM_PE];
   logic [RW-1:0] mem_d [NUM_PE];
   mode_e         mode_q, mode_d;
   bank_state_e   state_q, state_d;

   // The top only writes while the bank is not full, so row 0 always opens a tile.
   always_comb begin
      mem_d   = mem_q;
      mode_d  = mode_q;
      state_d = state_q;
      if (wr_en) begin
         mem_d[wr_row] = wr_data;
         if (wr_row == '0) begin
            mode_d = wr_mode;
         end
      end
      unique case (state_q)
         EMPTY:   if (wr_en && (wr_row == '0))     state_d = FILLING;
         FILLING: if (wr_en && (wr_row == LAST_ROW)) state_d = FULL;
         FULL:    if (rd_done)                       state_d = EMPTY;
         default:                                    state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PE; i++) begin
            mem_q[i] <= '0;
         end
         mode_q  <= MODE_PASS;
         state_q <= EMPTY;
      end else begin
         mem_q   <= mem_d;
         mode_q  <= mode_d;
         state_q <= state_d;
      end
   end

   assign full = (state_q == FULL);

   // Transpose picks column rd_idx across all rows; passthrough picks row rd_idx.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (mode_q == MODE_TRANSPOSE) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_idx*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx][i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/mtm_pp_unit.sv
// Ping-pong tile transposer: one bank fills while the other drains,
// sustaining one row per cycle with valid/ready on both sides.
module mtm_pp_unit
   import mtm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PE     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_val,
   output logic                         in_rdy,
   input  logic                         in_mode,
   input  logic [NUM_PE*DATA_WIDTH-1:0] input_row,
   output logic                         out_val,
   input  logic                         out_rdy,
   output logic [NUM_PE*DATA_WIDTH-1:0] output_row,
   output logic                         out_last
);

   localparam int CW = cnt_width(NUM_PE);
   localparam int RW = NUM_PE * DATA_WIDTH;
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PE - 1);

   logic          wr_bank_q, wr_bank_d;
   logic [CW-1:0] wr_row_q, wr_row_d;
   logic          rd_bank_q, rd_bank_d;
   logic [CW-1:0] rd_idx_q, rd_idx_d;

   logic          full0, full1;
   logic [RW-1:0] rd_data0, rd_data1;
   logic          in_fire, out_fire, rd_last;

   // Ready depends only on registered bank state, never on in_val.
   assign in_rdy     = !rst && !(wr_bank_q ? full1 : full0);
   assign out_val    = rd_bank_q ? full1 : full0;
   assign output_row = rd_bank_q ? rd_data1 : rd_data0;
   assign rd_last    = (rd_idx_q == LAST_IDX);
   assign out_last   = out_val && rd_last;
   assign in_fire    = in_val && in_rdy;
   assign out_fire   = out_val && out_rdy;

   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_row_d  = wr_row_q;
      rd_bank_d = rd_bank_q;
      rd_idx_d  = rd_idx_q;
      if (in_fire) begin
         if (wr_row_q == LAST_IDX) begin
            wr_row_d  = '0;
            wr_bank_d = !wr_bank_q;
         end else begin
            wr_row_d = wr_row_q + 1'b1;
         end
      end
      if (out_fire) begin
         if (rd_last) begin
            rd_idx_d  = '0;
            rd_bank_d = !rd_bank_q;
         end else begin
            rd_idx_d = rd_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
      end else begin
         wr_bank_q <= wr_bank_d;
         wr_row_q  <= wr_row_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
      end
   end

   mtm_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_PE     (NUM_PE)
   ) u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_fire && !wr_bank_q),
      .wr_row  (wr_row_q),
      .wr_data (input_row),
      .wr_mode (mode_e'(in_mode)),
      .rd_done (out_fire && rd_last && !rd_bank_q),
      .rd_idx  (rd_idx_q),
      .full    (full0),
      .rd_data (rd_data0)
   );

   mtm_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_PE     (NUM_PE)
   ) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_fire && wr_bank_q),
      .wr_row  (wr_row_q),
      .wr_data (input_row),
      .wr_mode (mode_e'(in_mode)),
      .rd_done (out_fire && rd_last && rd_bank_q),
      .rd_idx  (rd_idx_q),
      .full    (full1),
      .rd_data (rd_data1)
   );

endmodule

// File: tb/tb_mtm_pp_unit.sv
// Directed bench for mtm_pp_unit (DATA_WIDTH=8, NUM_PE=4) with hand-derived tiles.
module tb_mtm_pp_unit;

   localparam int BUDGET = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_val = 1'b0;
   logic        in_rdy;
   logic        in_mode = 1'b0;
   logic [31:0] input_row = '0;
   logic        out_val;
   logic        out_rdy = 1'b0;
   logic [31:0] output_row;
   logic        out_last;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   bit          exp_last_q[$];

   always #5 clk = ~clk;

   mtm_pp_unit #(
      .DATA_WIDTH (8),
      .NUM_PE     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_val     (in_val),
      .in_rdy     (in_rdy),
      .in_mode    (in_mode),
      .input_row  (input_row),
      .out_val    (out_val),
      .out_rdy    (out_rdy),
      .output_row (output_row),
      .out_last   (out_last)
   );

   function automatic logic [7:0] elem(input int r, input int c, input int off);
      return 8'(8'h10 * r + 8'h0A + c + off);
   endfunction

   function automatic logic [31:0] in_row(input int r, input int off);
      logic [31:0] v;
      for (int j = 0; j < 4; j++) v[j*8 +: 8] = elem(r, j, off);
      return v;
   endfunction

   function automatic logic [31:0] col_row(input int k, input int off);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = elem(i, k, off);
      return v;
   endfunction

   function automatic void push_tile(input int off, input bit transposed);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(transposed ? col_row(k, off) : in_row(k, off));
         exp_last_q.push_back(k == 3);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_tile(input int off, input bit mode0, input bit mode_rest, output int stalls);
      int w;
      stalls = 0;
      for (int r = 0; r < 4; r++) begin
         in_val    = 1'b1;
         input_row = in_row(r, off);
         in_mode   = (r == 0) ? mode0 : mode_rest;
         w = 0;
         while (!in_rdy && w < BUDGET) begin
            stalls++;
            step();
            w++;
         end
         if (w >= BUDGET) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_timeout: in_rdy stayed %b for %0d cycles, required 1", in_rdy, w);
            in_val = 1'b0;
            return;
         end
         step();
      end
      in_val = 1'b0;
   endtask

   task automatic collect(input int nrows, output int first_cyc, output int gaps);
      int got, cyc, prev;
      logic [31:0] e;
      bit el;
      got = 0; cyc = 0; prev = 0; first_cyc = -1; gaps = 0;
      while (got < nrows && cyc < BUDGET) begin
         if (out_val && out_rdy) begin
            if (first_cyc < 0) first_cyc = cyc;
            else if (cyc != prev + 1) gaps++;
            prev = cyc;
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            n_checks++;
            if (output_row !== e) begin
               n_fail++;
               $display("[TB] FAIL out_row[%0d]: got %h expected %h", got, output_row, e);
            end
            n_checks++;
            if (out_last !== el) begin
               n_fail++;
               $display("[TB] FAIL out_last[%0d]: got %b expected %b", got, out_last, el);
            end
            got++;
         end
         step();
         cyc++;
      end
      n_checks++;
      if (got != nrows) begin
         n_fail++;
         $display("[TB] FAIL collect_count: got %0d rows expected %0d", got, nrows);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({out_val, out_last, in_rdy} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got val/last/rdy %b expected 000", {out_val, out_last, in_rdy});
      end
      n_checks++;
      if (output_row !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_row: got %h expected 00000000", output_row);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL post_reset: got rdy/val %b%b expected 10", in_rdy, out_val);
      end
   endtask

   task automatic test_single_tile();
      int stalls, first, gaps;
      out_rdy = 1'b1;
      push_tile(0, 1'b1);
      fork
         send_tile(0, 1'b1, 1'b1, stalls);
         collect(4, first, gaps);
      join
      n_checks++;
      if (first !== 4 || gaps !== 0) begin
         n_fail++;
         $display("[TB] FAIL single_latency: got first=%0d gaps=%0d expected first=4 gaps=0", first, gaps);
      end
   endtask

   task automatic test_back_to_back();
      int stalls, first, gaps;
      out_rdy = 1'b1;
      push_tile(8'h00, 1'b1);
      push_tile(8'h40, 1'b1);
      push_tile(8'h80, 1'b1);
      fork
         begin
            int s;
            stalls = 0;
            send_tile(8'h00, 1'b1, 1'b1, s); stalls += s;
            send_tile(8'h40, 1'b1, 1'b1, s); stalls += s;
            send_tile(8'h80, 1'b1, 1'b1, s); stalls += s;
         end
         collect(12, first, gaps);
      join
      n_checks++;
      if (stalls !== 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_in_rdy: got %0d stall cycles expected 0", stalls);
      end
      n_checks++;
      if (first !== 4 || gaps !== 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_contig: got first=%0d gaps=%0d expected first=4 gaps=0", first, gaps);
      end
   endtask

   task automatic test_backpressure();
      int s0, s1;
      logic [31:0] e;
      bit el;
      out_rdy = 1'b0;
      send_tile(8'h00, 1'b1, 1'b1, s0);
      send_tile(8'h40, 1'b1, 1'b1, s1);
      n_checks++;
      if (s0 + s1 !== 0 || in_rdy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL bp_fill: got stalls=%0d in_rdy=%b expected 0 and 0", s0 + s1, in_rdy);
      end
      for (int c = 0; c < 20; c++) begin
         n_checks++;
         if (output_row !== 32'h3A2A1A0A || out_val !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_hold[%0d]: got %b/%h expected 1/3a2a1a0a", c, out_val, output_row);
         end
         step();
      end
      push_tile(8'h00, 1'b1);
      push_tile(8'h40, 1'b1);
      out_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         e  = exp_q.pop_front();
         el = exp_last_q.pop_front();
         n_checks++;
         if (out_val !== 1'b1 || output_row !== e || out_last !== el) begin
            n_fail++;
            $display("[TB] FAIL bp_drain[%0d]: got %b/%h/%b expected 1/%h/%b", k, out_val, output_row, out_last, e, el);
         end
         n_checks++;
         if (in_rdy !== (k >= 4)) begin
            n_fail++;
            $display("[TB] FAIL bp_in_rdy[%0d]: got %b expected %b", k, in_rdy, (k >= 4));
         end
         step();
      end
      n_checks++;
      if (out_val !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL bp_empty: got out_val %b expected 0", out_val);
      end
   endtask

   task automatic test_passthrough();
      int stalls, first, gaps;
      out_rdy = 1'b1;
      push_tile(0, 1'b0);
      fork
         send_tile(0, 1'b0, 1'b0, stalls);
         collect(4, first, gaps);
      join
   endtask

   task automatic test_mode_change();
      int stalls, first, gaps;
      out_rdy = 1'b1;
      push_tile(0, 1'b1);
      fork
         send_tile(0, 1'b1, 1'b0, stalls);
         collect(4, first, gaps);
      join
   endtask

   task automatic test_reset_mid_tile();
      int stalls, first, gaps;
      out_rdy = 1'b1;
      for (int r = 0; r < 2; r++) begin
         in_val    = 1'b1;
         in_mode   = 1'b1;
         input_row = in_row(r, 0);
         step();
      end
      in_val = 1'b0;
      rst    = 1'b1;
      #1;
      n_checks++;
      if ({out_val, out_last, in_rdy} !== 3'b000 || output_row !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset: got %b/%h expected 000/00000000", {out_val, out_last, in_rdy}, output_row);
      end
      step();
      rst = 1'b0;
      step();
      push_tile(8'h40, 1'b1);
      fork
         send_tile(8'h40, 1'b1, 1'b1, stalls);
         collect(4, first, gaps);
      join
      repeat (3) begin
         n_checks++;
         if (out_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stale_rows: got out_val %b expected 0", out_val);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_back_to_back();
      test_backpressure();
      test_passthrough();
      test_mode_change();
      test_reset_mid_tile();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
